// File: rtl/prf_ready_table.sv
// rtl/prf_ready_table.sv - physical register ready table with CDB wakeup and bypass
module prf_ready_table #(
  parameter int N      = 2,
  parameter int PRF_SZ = 64,
  parameter int PRN_W  = $clog2(PRF_SZ),
  parameter int NUM_Q  = 2*N,
  parameter int CNT_W  = $clog2(PRF_SZ+1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N-1:0]                cdb_valid,
  input  logic [N-1:0][PRN_W-1:0]     cdb_prn,
  input  logic [N-1:0]                alloc_valid,
  input  logic [N-1:0][PRN_W-1:0]     alloc_prn,
  input  logic [NUM_Q-1:0][PRN_W-1:0] query_prn,
  output logic [NUM_Q-1:0]            query_ready,
  output logic [PRF_SZ-1:0]           ready_vec,
  output logic [CNT_W-1:0]            num_busy,
  output logic                        err_flag
);

  logic [PRF_SZ-1:0] set_mask;
  logic [PRF_SZ-1:0] clr_mask;
  logic [PRF_SZ-1:0] ready_next;
  logic [CNT_W-1:0]  busy_next;
  logic              err_now;

  function automatic logic in_range(input logic [PRN_W-1:0] p);
    return {1'b0, p} < (PRN_W+1)'(PRF_SZ);
  endfunction

  // Masks are built first so the error checks can see what the other side
  // of the bundle does to the same PRN this cycle.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    err_now  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cdb_valid[i] && in_range(cdb_prn[i]) && cdb_prn[i] != '0)
        set_mask[cdb_prn[i]] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (alloc_valid[i]) begin
        if (!in_range(alloc_prn[i])) begin
          err_now = 1'b1;
        end else if (alloc_prn[i] != '0) begin
          if (clr_mask[alloc_prn[i]])
            err_now = 1'b1;
          // A busy PRN completing on the CDB this cycle may be reused at once.
          if (!ready_vec[alloc_prn[i]] && !set_mask[alloc_prn[i]])
            err_now = 1'b1;
          clr_mask[alloc_prn[i]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cdb_valid[i]) begin
        if (!in_range(cdb_prn[i])) begin
          err_now = 1'b1;
        end else if (cdb_prn[i] != '0) begin
          if (ready_vec[cdb_prn[i]] && !clr_mask[cdb_prn[i]])
            err_now = 1'b1;
        end
      end
    end
  end

  // Allocation wins over a same-cycle completion of the same PRN.
  always_comb begin
    ready_next    = (ready_vec | set_mask) & ~clr_mask;
    ready_next[0] = 1'b1;
    busy_next     = '0;
    for (int k = 0; k < PRF_SZ; k++)
      busy_next = busy_next + CNT_W'(~ready_next[k]);
  end

  always_comb begin
    query_ready = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (in_range(query_prn[q]))
        query_ready[q] = ready_vec[query_prn[q]];
      for (int i = 0; i < N; i++) begin
        if (cdb_valid[i] && in_range(cdb_prn[i]) && cdb_prn[i] == query_prn[q])
          query_ready[q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_vec <= '1;
      num_busy  <= '0;
      err_flag  <= 1'b0;
    end else begin
      ready_vec <= ready_next;
      num_busy  <= busy_next;
      err_flag  <= err_flag | err_now;
    end
  end

endmodule

// File: doc/prf_ready_table.md
Name: prf_ready_table

Overview:
- Receiving end of the CDB broadcast.
- Holds one ready bit per physical register:
  - dispatch allocations of a destination PRN clear the bit;
  - CDB completions set it again.
- Answers combinational source-operand readiness queries from dispatch/RS, with same-cycle CDB bypass, so newly dispatched entries never miss a wakeup.
- Sits beside the map table, fed by the CDB stage output and the dispatch stage.

Parameters:
- N, `N, superscalar width: number of CDB ports and number of allocation ports.
- PRF_SZ, 64, number of physical registers.
- PRN_W, $clog2(PRF_SZ), PRN width.
- NUM_Q, 2*`N, number of source query ports (rs1/rs2 per dispatch slot).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cdb_valid  in  N  per-port CDB broadcast valid.
- cdb_prn  in  N x PRN_W  destination PRN completed on each CDB port.
- alloc_valid  in  N  per-slot dispatch allocation valid.
- alloc_prn  in  N x PRN_W  newly allocated destination PRN per slot.
- query_prn  in  NUM_Q x PRN_W  source PRNs being checked.
- query_ready  out  NUM_Q  operand ready (combinational).
- ready_vec  out  PRF_SZ  registered ready bits (debug / RS reload).
- num_busy  out  $clog2(PRF_SZ+1)  registered count of not-ready PRNs.
- err_flag  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - ready_vec = all ones;
  - num_busy = 0;
  - err_flag = 0.
  - Inputs are ignored while reset is high.
- PRN 0 is the zero register:
  - hardwired ready;
  - alloc and cdb to PRN 0 are ignored;
  - alloc/cdb to PRN 0 never raise err_flag.
- Allocation: alloc_valid[i] with alloc_prn[i]=p clears ready[p] at the next rising edge. Latency 1.
- Completion: cdb_valid[i] with cdb_prn[i]=p sets ready[p] at the next rising edge. Latency 1.
- Same PRN allocated and broadcast in the same cycle: allocation wins, so the bit ends 0. This models a freed-then-reused PRN.
- Duplicate allocations of one PRN across slots in the same cycle behave as a single clear and set err_flag.
- query_ready[q] = ready[query_prn[q]] OR (any cdb_valid[i] with cdb_prn[i]==query_prn[q]).
  - Purely combinational.
  - Reflects state before this cycle's allocations; intra-bundle RAW is handled by dispatch, not here.
- num_busy = population count of ~ready_vec after the update, registered with the table. Compute it as a popcount of the next state, not incrementally, so it is correct under simultaneous set/clear.
- err_flag sets (sticky until reset) on any of:
  - cdb to a PRN already ready and not allocated this cycle;
  - alloc to a PRN already busy;
  - duplicate alloc in the same cycle.
- No handshake and no backpressure; the table accepts all ports every cycle.
- Out-of-range PRNs (>= PRF_SZ, when PRF_SZ is not a power of two) are ignored and set err_flag.

Test Plan (N=2, PRF_SZ=64):
- Reset check: assert reset mid-run after allocating PRN 5.
  - ready_vec = 64'hFFFF_FFFF_FFFF_FFFF immediately (before the next edge).
  - num_busy = 0, err_flag = 0.
- Alloc PRN 7 and 9 in cycle 0.
  - Cycle 1: ready[7]=ready[9]=0, num_busy=2.
  - query_prn=7 gives query_ready=0.
- With PRN 7 busy, cdb_valid[0]=1, cdb_prn[0]=7 in cycle 2.
  - query_prn=7 reads 1 in cycle 2 (bypass).
  - ready[7]=1 and num_busy=1 in cycle 3.
- Same cycle: alloc PRN 12 and cdb PRN 12, with PRN 12 previously busy.
  - Next cycle ready[12]=0, num_busy unchanged, err_flag=0.
- Alloc PRN 0 and cdb PRN 0.
  - ready[0] stays 1, num_busy unchanged, err_flag=0.
  - Then cdb PRN 20 while it is ready: err_flag=1 and stays 1 until reset.
- Both alloc slots target PRN 30 in one cycle.
  - ready[30]=0, num_busy +1 only, err_flag=1.
